if_program_loader: RTL and testbench
====================================

Name: if_program_loader

Overview:
- Upstream feeder of the IF-stage instruction memory write port.
- Collects a byte stream from the debug/UART receiver, assembles bytes big-endian into 32-bit instructions and issues one-cycle write strobes with sequential word-aligned addresses.
- Stops when it sees the halt marker word or when program memory is exhausted.
- Its o_write/o_address/o_instruction drive the memory's i_write/i_address/i_instruction directly.

Parameters:
- NB_ADDR, 32, address width; matches instruction memory.
- NB_INST, 32, instruction width; fixed at 4 bytes.
- NB_ROM_SIZE, 10, log2 of memory entries.
- ADDR_STEP, 4, address increment per written word; matches PC increment.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  begin a new load; level sampled each cycle.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle.
- o_write  out  1  one-cycle write strobe to instruction memory.
- o_address  out  NB_ADDR  write address, valid when o_write=1.
- o_instruction  out  NB_INST  assembled word, valid when o_write=1.
- o_busy  out  1  high in LOAD state.
- o_done  out  1  high in DONE state.
- o_error  out  1  high in ERROR state (memory overflow).
- o_word_count  out  NB_ROM_SIZE+1  words written in the current/last load, including the halt word.

Behaviour:
- Reset: state=IDLE. o_write=0, o_address=0, o_instruction=0, o_busy=0, o_done=0, o_error=0, o_word_count=0.
- Reset also clears the byte counter (0..3), the shift register and the next-address register.
- Reset mid-load discards any partial word; no write is issued.
- States:
  - IDLE: i_start=1 -> LOAD. Clear next-address, byte counter and o_word_count.
  - LOAD: each cycle with i_rx_valid=1 shifts in i_rx_data; the first byte becomes bits [31:24], the fourth byte bits [7:0]. Byte counter increments and wraps 3->0. i_start is ignored.
  - Word completes (fourth byte accepted in cycle N), limit check: if next-address <= 2**NB_ROM_SIZE - ADDR_STEP:
    - In cycle N+1, o_write=1, o_address=next-address, o_instruction=assembled word.
    - next-address += ADDR_STEP and o_word_count += 1, both visible in cycle N+1.
  - Word completes and next-address exceeds that limit: no write; -> ERROR in cycle N+1.
  - Completed word == HALT_WORD (and within limit): the halt word is written (cycle N+1), then state=DONE in cycle N+1. o_busy falls and o_done rises in the same cycle as the write strobe.
  - DONE / ERROR: hold outputs (o_write=0). i_rx_valid is ignored. i_start=1 -> LOAD with the same clearing as in IDLE.
- o_write is registered; it is never high on two consecutive cycles unless fourth bytes arrive on consecutive cycles. Byte arrival back-to-back every cycle is supported: a byte arriving in the strobe cycle is accepted normally.
- o_address and o_instruction hold their last values when o_write=0. Only o_write qualifies them.
- Simultaneous i_reset and any input: reset wins.
- Simultaneous i_start and i_rx_valid in IDLE/DONE/ERROR: the byte is dropped; loading starts from the next byte.
- Address arithmetic is unsigned NB_ADDR wide. The overflow check uses next-address before the increment, so wrap-around can never occur.
- Latency: fourth byte strobe to write strobe = 1 cycle.

Test Plan:
- Reset then start, send bytes 00 43 08 21, 08 00 00 0B, FF FF FF FF -> three writes:
  - 0x00430821 @0
  - 0x0800000B @4
  - 0xFFFFFFFF @8
  - o_done=1 in the cycle of the third strobe; o_word_count=3; o_busy=0.
- Bytes spaced irregularly (gaps of 0..20 cycles), including four bytes on consecutive cycles -> each write exactly 1 cycle after its fourth byte; byte order preserved.
- Reset asserted after 2 bytes of the second word -> no further write, all outputs 0. Then start and send 4 bytes AA BB CC DD -> write 0xAABBCCDD @0.
- Send 1025 non-halt words (NB_ROM_SIZE=10, ADDR_STEP=4):
  - 256 writes, last one @1020.
  - The 257th completed word produces no write and o_error=1.
  - Further bytes are ignored.
- After DONE, pulse i_start, send 01 02 03 04 -> write 0x01020304 @0; o_word_count restarts at 1.
- In IDLE, send bytes with no start -> no write, state stays IDLE. Start and i_rx_valid asserted in the same cycle -> that byte is dropped.

Source files
------------

// File: rtl/if_program_loader.sv
// ==== if_program_loader : byte stream -> big-endian words -> IMEM write port (rev 1.0) ====
`default_nettype none

module if_program_loader #(
  parameter int                 NB_ADDR     = 32,
  parameter int                 NB_INST     = 32,
  parameter int                 NB_ROM_SIZE = 10,
  parameter int                 ADDR_STEP   = 4,
  parameter logic [NB_INST-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_write,
  output logic [NB_ADDR-1:0]     o_address,
  output logic [NB_INST-1:0]     o_instruction,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [NB_ROM_SIZE:0]   o_word_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Last address that still fits a full word; compared before incrementing so no wrap.
  localparam logic [NB_ADDR-1:0]   ADDR_LIMIT = NB_ADDR'(2**NB_ROM_SIZE - ADDR_STEP);
  localparam logic [NB_ADDR-1:0]   ADDR_INC   = NB_ADDR'(ADDR_STEP);
  localparam logic [NB_ROM_SIZE:0] CNT_ONE    = 1;

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [NB_INST-9:0]     shift_q, shift_d;
  logic [NB_ADDR-1:0]     next_addr_q, next_addr_d;
  logic                   write_q, write_d;
  logic [NB_ADDR-1:0]     address_q, address_d;
  logic [NB_INST-1:0]     instruction_q, instruction_d;
  logic [NB_ROM_SIZE:0]   word_count_q, word_count_d;
  logic [NB_INST-1:0]     word_w;

  // The fourth byte is appended directly, so the word is written the cycle after it arrives.
  assign word_w = {shift_q, i_rx_data};

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    next_addr_d   = next_addr_q;
    write_d       = 1'b0;
    address_d     = address_q;
    instruction_d = instruction_q;
    word_count_d  = word_count_q;

    case (state_q)
      ST_LOAD: begin
        if (i_rx_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = word_w[NB_INST-9:0];
          if (byte_cnt_q == 2'd3) begin
            if (next_addr_q <= ADDR_LIMIT) begin
              write_d       = 1'b1;
              address_d     = next_addr_q;
              instruction_d = word_w;
              next_addr_d   = next_addr_q + ADDR_INC;
              word_count_d  = word_count_q + CNT_ONE;
              if (word_w == HALT_WORD) begin
                state_d = ST_DONE;
              end
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
      end
      default: begin
        if (i_start) begin
          state_d      = ST_LOAD;
          byte_cnt_d   = 2'd0;
          shift_d      = '0;
          next_addr_d  = '0;
          word_count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 2'd0;
      shift_q       <= '0;
      next_addr_q   <= '0;
      write_q       <= 1'b0;
      address_q     <= '0;
      instruction_q <= '0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      next_addr_q   <= next_addr_d;
      write_q       <= write_d;
      address_q     <= address_d;
      instruction_q <= instruction_d;
      word_count_q  <= word_count_d;
    end
  end

  assign o_write       = write_q;
  assign o_address     = address_q;
  assign o_instruction = instruction_q;
  assign o_busy        = (state_q == ST_LOAD);
  assign o_done        = (state_q == ST_DONE);
  assign o_error       = (state_q == ST_ERROR);
  assign o_word_count  = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_program_loader.sv
// ==== tb_if_program_loader : random byte streams checked against a word-level reference model (rev 1.0) ====
`default_nettype none

module tb_if_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        busy, done, err;
  logic [10:0] wcnt;

  int total = 0;
  int bad   = 0;

  if_program_loader dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_write      (wr),
    .o_address    (addr),
    .o_instruction(inst),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (err),
    .o_word_count (wcnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode of the loader, bytes of the word in progress, words written so far.
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;
  localparam int MEM_BYTES = 1024;
  int          m_mode  = M_IDLE;
  logic [7:0]  m_bytes[$];
  int          m_words = 0;
  logic        m_write = 1'b0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_inst  = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit v, input logic [7:0] d);
    longint unsigned w;
    m_write = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_bytes.delete(); m_words = 0; m_addr = 0; m_inst = 0;
    end else if (m_mode == M_LOAD) begin
      if (v) begin
        m_bytes.push_back(d);
        if (m_bytes.size() == 4) begin
          w = m_bytes[0] * 64'd16777216 + m_bytes[1] * 64'd65536 + m_bytes[2] * 64'd256 + m_bytes[3];
          m_bytes.delete();
          if (m_words * 4 + 4 <= MEM_BYTES) begin
            m_write = 1'b1;
            m_addr  = 32'(m_words * 4);
            m_inst  = w[31:0];
            m_words++;
            if (w == 64'hFFFF_FFFF) m_mode = M_DONE;
          end else begin
            m_mode = M_ERR;
          end
        end
      end
    end else if (s) begin
      m_mode = M_LOAD; m_bytes.delete(); m_words = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input logic [7:0] d);
    rst = r; start = s; rx_valid = v; rx_data = d;
    @(posedge clk);
    model_update(r, s, v, d);
    #1;
    check("write",  {31'd0, wr},   {31'd0, m_write});
    check("addr",   addr,          m_addr);
    check("inst",   inst,          m_inst);
    check("busy",   {31'd0, busy}, {31'd0, m_mode == M_LOAD});
    check("done",   {31'd0, done}, {31'd0, m_mode == M_DONE});
    check("error",  {31'd0, err},  {31'd0, m_mode == M_ERR});
    check("wcount", {21'd0, wcnt}, 32'(m_words));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    step(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send(t[31:24], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
      t = t << 8;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b1, 1'b0, 8'd0);
  endtask

  initial begin
    do_reset();
    idle(2);

    // Example program: three words ending in the halt marker.
    do_start();
    send_word(32'h0043_0821, 0);
    send_word(32'h0800_000B, 0);
    send_word(32'hFFFF_FFFF, 0);
    check("example_done",  {31'd0, done}, 32'd1);
    check("example_count", {21'd0, wcnt}, 32'd3);
    idle(3);

    // Irregular byte spacing, one back-to-back word, then halt.
    do_start();
    for (int k = 0; k < 6; k++) send_word({$urandom_range(0, 254), 24'($urandom)}, 20);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'hFFFF_FFFF, 20);
    idle(2);

    // Reset in the middle of the second word, then a fresh load.
    do_start();
    send_word(32'h5566_7788, 3);
    send(8'h9A, 2);
    send(8'hBC, 0);
    do_reset();
    idle(4);
    do_start();
    send_word(32'hAABB_CCDD, 2);
    check("reload_addr", addr, 32'd0);
    check("reload_inst", inst, 32'hAABB_CCDD);
    idle(2);

    // Fill memory and overflow it with one extra word.
    do_reset();
    do_start();
    for (int k = 0; k < 1025; k++) send_word({8'($urandom_range(0, 254)), 24'($urandom)}, 0);
    check("ovf_error", {31'd0, err},  32'd1);
    check("ovf_last",  addr,          32'd1020);
    check("ovf_count", {21'd0, wcnt}, 32'd256);
    for (int k = 0; k < 10; k++) send(8'($urandom), int'($urandom_range(0, 2)));

    // Restart straight out of ERROR into DONE, then again out of DONE.
    do_start();
    send_word(32'hFFFF_FFFF, 1);
    idle(2);
    do_start();
    send_word(32'h0102_0304, 1);
    check("restart_count", {21'd0, wcnt}, 32'd1);
    idle(2);

    // Bytes without a start are ignored; the byte arriving with start is dropped.
    do_reset();
    for (int k = 0; k < 6; k++) send(8'($urandom), 1);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    send_word(32'h1122_3344, 1);
    check("drop_inst", inst, 32'h1122_3344);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
